// File: rtl/data_mem_ctrl.sv
// Data-memory controller: word-addressed RAM behind a fixed wait-state handshake.
// It latches each load/store request, stalls the datapath until the access
// completes, and flags misaligned, out-of-range or conflicting requests.
module data_mem_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        mw,
    input  logic        mr,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg, din_reg;
    logic        mw_reg, mr_reg;
    logic        err_reg;
    logic [31:0] data_out_reg;

    logic [31:0] mem_array [0:(2**ADDR_W)-1];

    logic        accept;
    logic        commit;
    logic [31:0] c_addr, c_din;
    logic        c_mw, c_mr;
    logic        c_err;
    logic [ADDR_W-1:0] c_idx;
    logic        mem_we;

    // A request with neither MW nor MR set is not an access and is ignored.
    assign accept = req & (mw | mr) & (state_reg != ST_WAIT);

    // With zero wait states the access commits on its acceptance edge, so the
    // live inputs are used; otherwise the request latched at acceptance is used.
    generate
        if (WAIT_CYCLES == 0) begin : g_direct
            assign c_addr = addr;
            assign c_din  = data_in;
            assign c_mw   = mw;
            assign c_mr   = mr;
            assign commit = accept;
        end else begin : g_latched
            assign c_addr = addr_reg;
            assign c_din  = din_reg;
            assign c_mw   = mw_reg;
            assign c_mr   = mr_reg;
            assign commit = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);
        end
    endgenerate

    assign c_err  = (|c_addr[1:0]) | (|c_addr[31:ADDR_W+2]) | (c_mw & c_mr);
    assign c_idx  = c_addr[ADDR_W+1:2];
    // rst_n gating keeps a request seen during reset from committing a write.
    assign mem_we = commit & ~c_err & c_mw & rst_n;

    assign done     = (state_reg == ST_DONE);
    assign err      = done & err_reg;
    assign stall    = (state_reg == ST_WAIT) | accept;
    assign data_out = data_out_reg;

    // State, wait counter, latched request and completion status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= 32'd0;
            din_reg   <= 32'd0;
            mw_reg    <= 1'b0;
            mr_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg <= addr;
                din_reg  <= data_in;
                mw_reg   <= mw;
                mr_reg   <= mr;
            end
            if (commit) begin
                err_reg <= c_err;
            end
        end
    end

    // Next-state logic: IDLE/DONE accept, WAIT counts down, DONE lasts one cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_next = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
                    cnt_next   = CNT_INIT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[c_idx] <= c_din;
        end
    end

    // Registered RAM read; the result holds until the next good load completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_reg <= 32'd0;
        end else if (commit & ~c_err & c_mr) begin
            data_out_reg <= mem_array[c_idx];
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Data-memory controller for the RISC datapath; the source of the DATA_OUT word that mux_Dprime routes onto Bus D' when MD=1.
- Accepts load/store requests from the execute stage: address from Bus A, store data from Bus B.
- Models a word-addressed RAM with a fixed number of wait states.
- Stalls the datapath until each access completes and flags misaligned or out-of-range accesses.

Parameters:
- ADDR_W, 8, word-address width; memory depth is 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and completion; legal range 0..15.

Ports:
- CLK  input  1  single system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- REQ  input  1  access request; sampled only in IDLE or DONE.
- MW  input  1  memory write (store).
- MR  input  1  memory read (load).
- ADDR  input  32  byte address from Bus A.
- DATA_IN  input  32  store data from Bus B.
- DATA_OUT  output  32  load result, to mux_Dprime DATA_OUT.
- STALL  output  1  freezes the PC and pipeline registers while high.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  error flag for the completing access; valid only while DONE is high.

Behaviour:
- Reset (RST_N low, asynchronous):
  - State goes to IDLE; wait counter cleared; latched request cleared.
  - DATA_OUT=0, DONE=0, ERR=0.
  - Memory array contents are not cleared by reset; simulation initialises the array to 0.
- States: IDLE, WAIT, DONE.
- Acceptance:
  - A request is accepted when REQ=1 in IDLE or DONE.
  - ADDR, DATA_IN, MW and MR are latched at acceptance; later changes to these inputs have no effect on that access.
  - REQ=1 with MW=0 and MR=0 is ignored: no state change, STALL stays low.
- Transitions:
  - IDLE/DONE plus accepted request: go to WAIT with counter=WAIT_CYCLES-1 when WAIT_CYCLES>0; go directly to DONE when WAIT_CYCLES=0.
  - WAIT: decrement the counter; at counter=0 go to DONE.
  - DONE with no accepted request: go to IDLE.
- STALL is combinational:
  - High in WAIT.
  - High in IDLE or DONE while a valid request is being accepted.
  - Low otherwise, including the DONE cycle when no new request is present.
- Latency: acceptance edge to DONE high is WAIT_CYCLES+1 cycles. A back-to-back request presented in the DONE cycle is accepted on that edge with no idle bubble.
- Error checks, evaluated on the latched request:
  - misaligned: ADDR[1:0]!=0.
  - out of range: ADDR[31:ADDR_W+2]!=0.
  - conflict: MW=1 and MR=1 together.
  - Any error: the access still goes through WAIT, ERR=1 with DONE, memory is not written, DATA_OUT is unchanged.
- Write: mem[ADDR[ADDR_W+1:2]] <= DATA_IN on the edge entering DONE. DATA_OUT is unchanged.
- Read: DATA_OUT <= mem[ADDR[ADDR_W+1:2]] on the edge entering DONE. DATA_OUT holds that value until the next successful read completes.
- Read after write to the same word, back-to-back: the read returns the newly written data (the write commits before the read's sample edge).
- Outputs:
  - DONE is high for exactly one cycle per accepted access, and only in state DONE.
  - ERR is low whenever DONE is low.
- REQ during WAIT is ignored; the datapath is stalled and holds REQ.
- Reset asserted mid-access: the access is aborted, no memory write occurs unless the commit edge has already passed, and no DONE is produced.

Test Plan:
- Store then load, WAIT_CYCLES=2: write 0xDEADBEEF to ADDR 0x10, then read 0x10 -> DATA_OUT=0xDEADBEEF 3 cycles after read acceptance; STALL high 3 cycles per access; one DONE per access.
- WAIT_CYCLES=0: read of address 0x0 after reset -> DONE the cycle after acceptance, DATA_OUT=0; STALL high only in the request cycle.
- Misaligned store to 0x13 with DATA_IN 0x1234 -> ERR=1 with DONE; a subsequent read of 0x10 returns the prior contents, unchanged.
- Out of range: ADDR=0x400 with ADDR_W=8 -> ERR=1, DATA_OUT keeps its previous value.
- Back-to-back: write 0xA5A5A5A5 to 0x20 with a read of 0x20 presented in the write's DONE cycle -> read returns 0xA5A5A5A5 with no IDLE cycle between the accesses.
- Conflict and reset:
  - MW=MR=1 -> ERR=1, no write.
  - Separate case: RST_N pulsed low during WAIT of a read -> DONE never asserts, DATA_OUT=0, state IDLE, STALL low.
